// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag bit positions, WB/MEM select encodings, datapath defaults
// and the MEM-stage control bundle.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 8;
  localparam int unsigned CPU_REG_AW = 2;
  localparam int unsigned CPU_FLAG_W = 4;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  localparam int unsigned WB_SEL_W  = 3;
  localparam int unsigned MEM_SRC_W = 2;

  typedef enum logic [WB_SEL_W-1:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_SP    = 3'd2,
    WB_IMM   = 3'd3,
    WB_PC    = 3'd4,
    WB_STORE = 3'd5
  } wb_sel_e;

  typedef enum logic [MEM_SRC_W-1:0] {
    MEM_SRC_ALU = 2'd0,
    MEM_SRC_SP  = 2'd1,
    MEM_SRC_SPM = 2'd2,
    MEM_SRC_IMM = 2'd3
  } mem_src_e;

  typedef struct packed {
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 stack_push;
    logic                 stack_pop;
    logic [WB_SEL_W-1:0]  wb_sel;
    logic [MEM_SRC_W-1:0] mem_src;
  } mem_ctrl_t;

endpackage

// File: rtl/ccr_unit.sv
// Architectural condition-code register with commit priority logic.
// Optional interrupt shadow copy when FLAG_SHADOW_EN is defined.
module ccr_unit
  import cpu_pkg::*;
#(
  parameter int unsigned FLAG_W = CPU_FLAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              commit,
  input  logic              restore_flags,
  input  logic [FLAG_W-1:0] restore_value,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FLAG_W-1:0] flags_we,
  input  logic              setc,
  input  logic              clrc,
  input  logic              int_save,
  input  logic              int_restore,
  output logic [FLAG_W-1:0] ccr
);

  logic [FLAG_W-1:0] ccr_q, ccr_d;
  logic [FLAG_W-1:0] upd;

`ifdef FLAG_SHADOW_EN
  logic [FLAG_W-1:0] shadow_q, shadow_d;
`else
  logic unused_shadow_c;
  assign unused_shadow_c = ^{stall, int_save, int_restore};
`endif

  // Commit update: RTI image, else masked ALU flags with CLRC beating SETC on C.
  always_comb begin
    ccr_d = ccr_q;
    upd   = (ccr_q & ~flags_we) | (alu_flags & flags_we);
    if (clrc) begin
      upd[FLAG_C] = 1'b0;
    end else if (setc) begin
      upd[FLAG_C] = 1'b1;
    end
    if (commit) begin
      ccr_d = restore_flags ? restore_value : upd;
    end
`ifdef FLAG_SHADOW_EN
    shadow_d = shadow_q;
    if (!stall) begin
      if (int_restore) begin
        ccr_d = shadow_q;
      end else if (int_save) begin
        shadow_d = ccr_q;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccr_q <= '0;
    end else begin
      ccr_q <= ccr_d;
    end
  end

`ifdef FLAG_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign ccr = ccr_q;

endmodule

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall/flush handling; owns the CCR via ccr_unit.
// Build option: FLAG_SHADOW_EN enables the interrupt flag shadow in ccr_unit.
module ex_mem_register
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned REG_AW = CPU_REG_AW,
  parameter int unsigned FLAG_W = CPU_FLAG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic                 ex_reg_write,
  input  logic                 ex_mem_read,
  input  logic                 ex_mem_write,
  input  logic                 ex_stack_push,
  input  logic                 ex_stack_pop,
  input  logic [WB_SEL_W-1:0]  ex_wb_sel,
  input  logic [MEM_SRC_W-1:0] ex_mem_src,
  input  logic [REG_AW-1:0]    ex_rd,
  input  logic [DATA_W-1:0]    ex_alu_result,
  input  logic [DATA_W-1:0]    ex_store_data,
  input  logic [DATA_W-1:0]    ex_sp_value,
  input  logic [FLAG_W-1:0]    ex_alu_flags,
  input  logic [FLAG_W-1:0]    ex_flags_we,
  input  logic                 ex_setc,
  input  logic                 ex_clrc,
  input  logic                 ex_restore_flags,
  input  logic [FLAG_W-1:0]    restore_value,
  input  logic                 int_save,
  input  logic                 int_restore,
  output logic                 mem_valid,
  output logic                 mem_reg_write,
  output logic                 mem_mem_read,
  output logic                 mem_mem_write,
  output logic                 mem_stack_push,
  output logic                 mem_stack_pop,
  output logic [WB_SEL_W-1:0]  mem_wb_sel,
  output logic [MEM_SRC_W-1:0] mem_mem_src,
  output logic [REG_AW-1:0]    mem_rd,
  output logic [DATA_W-1:0]    mem_alu_result,
  output logic [DATA_W-1:0]    mem_store_data,
  output logic [DATA_W-1:0]    mem_sp_value,
  output logic [FLAG_W-1:0]    ccr
);

  mem_ctrl_t          ex_ctrl_c;
  mem_ctrl_t          ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  logic [REG_AW-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0]  alu_q, alu_d;
  logic [DATA_W-1:0]  store_q, store_d;
  logic [DATA_W-1:0]  sp_q, sp_d;
  logic               commit_c;

  assign commit_c  = ex_valid & ~stall & ~flush;
  assign ex_ctrl_c = '{reg_write:  ex_reg_write,
                       mem_read:   ex_mem_read,
                       mem_write:  ex_mem_write,
                       stack_push: ex_stack_push,
                       stack_pop:  ex_stack_pop,
                       wb_sel:     ex_wb_sel,
                       mem_src:    ex_mem_src};

  // Flush inserts a zeroed bubble, stall holds, otherwise capture (controls zeroed when invalid).
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    alu_d   = alu_q;
    store_d = store_q;
    sp_d    = sp_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
      rd_d    = '0;
      alu_d   = '0;
      store_d = '0;
      sp_d    = '0;
    end else if (!stall) begin
      valid_d = ex_valid;
      ctrl_d  = ex_valid ? ex_ctrl_c : '0;
      rd_d    = ex_valid ? ex_rd : '0;
      alu_d   = ex_alu_result;
      store_d = ex_store_data;
      sp_d    = ex_sp_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      alu_q   <= '0;
      store_q <= '0;
      sp_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      sp_q    <= sp_d;
    end
  end

  ccr_unit #(.FLAG_W(FLAG_W)) u_ccr (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .commit        (commit_c),
    .restore_flags (ex_restore_flags),
    .restore_value (restore_value),
    .alu_flags     (ex_alu_flags),
    .flags_we      (ex_flags_we),
    .setc          (ex_setc),
    .clrc          (ex_clrc),
    .int_save      (int_save),
    .int_restore   (int_restore),
    .ccr           (ccr)
  );

  assign mem_valid      = valid_q;
  assign mem_reg_write  = ctrl_q.reg_write;
  assign mem_mem_read   = ctrl_q.mem_read;
  assign mem_mem_write  = ctrl_q.mem_write;
  assign mem_stack_push = ctrl_q.stack_push;
  assign mem_stack_pop  = ctrl_q.stack_pop;
  assign mem_wb_sel     = ctrl_q.wb_sel;
  assign mem_mem_src    = ctrl_q.mem_src;
  assign mem_rd         = rd_q;
  assign mem_alu_result = alu_q;
  assign mem_store_data = store_q;
  assign mem_sp_value   = sp_q;

endmodule

// File: tb/tb_ex_mem_register.sv
// Scoreboard bench for ex_mem_register: driver queues hand-computed expectations,
// monitor pops one per cycle and compares. FLAG_SHADOW_EN selects the shadow expectations.
module tb_ex_mem_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall, flush, ex_valid;
  logic       ex_reg_write, ex_mem_read, ex_mem_write, ex_stack_push, ex_stack_pop;
  logic [2:0] ex_wb_sel;
  logic [1:0] ex_mem_src, ex_rd;
  logic [7:0] ex_alu_result, ex_store_data, ex_sp_value;
  logic [3:0] ex_alu_flags, ex_flags_we, restore_value;
  logic       ex_setc, ex_clrc, ex_restore_flags, int_save, int_restore;

  logic       mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_stack_push, mem_stack_pop;
  logic [2:0] mem_wb_sel;
  logic [1:0] mem_mem_src, mem_rd;
  logic [7:0] mem_alu_result, mem_store_data, mem_sp_value;
  logic [3:0] ccr;

  ex_mem_register dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_stack_push(ex_stack_push), .ex_stack_pop(ex_stack_pop), .ex_wb_sel(ex_wb_sel),
    .ex_mem_src(ex_mem_src), .ex_rd(ex_rd), .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data), .ex_sp_value(ex_sp_value), .ex_alu_flags(ex_alu_flags),
    .ex_flags_we(ex_flags_we), .ex_setc(ex_setc), .ex_clrc(ex_clrc),
    .ex_restore_flags(ex_restore_flags), .restore_value(restore_value),
    .int_save(int_save), .int_restore(int_restore),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_stack_push(mem_stack_push), .mem_stack_pop(mem_stack_pop),
    .mem_wb_sel(mem_wb_sel), .mem_mem_src(mem_mem_src), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
    .mem_sp_value(mem_sp_value), .ccr(ccr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  chk;   // bit0 ccr, bit1 valid+controls, bit2 data
    logic [12:0] ctrl;
    logic [23:0] data;
    logic [3:0]  ccr;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [2:0] C_CCR = 3'b001;
  localparam logic [2:0] C_CTL = 3'b010;
  localparam logic [2:0] C_ALL = 3'b111;

  function automatic logic [12:0] ctl(input logic v, input logic rw, input logic mr, input logic mw,
                                      input logic pu, input logic po, input logic [2:0] wb,
                                      input logic [1:0] ms, input logic [1:0] rd);
    return {v, rw, mr, mw, pu, po, wb, ms, rd};
  endfunction

  // Monitor: outputs are presented every cycle; compare #1 after the rising edge.
  always begin
    exp_t        e;
    logic [12:0] a_ctl;
    logic [23:0] a_dat;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e     = sb.pop_front();
      a_ctl = {mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_stack_push,
               mem_stack_pop, mem_wb_sel, mem_mem_src, mem_rd};
      a_dat = {mem_alu_result, mem_store_data, mem_sp_value};
      if (e.chk[0]) begin
        n_chk++;
        if (ccr === e.ccr) n_pass++;
        else $display("FAIL %s.ccr: got %b expected %b", e.nm, ccr, e.ccr);
      end
      if (e.chk[1]) begin
        n_chk++;
        if (a_ctl === e.ctrl) n_pass++;
        else $display("FAIL %s.ctrl: got %b expected %b", e.nm, a_ctl, e.ctrl);
      end
      if (e.chk[2]) begin
        n_chk++;
        if (a_dat === e.data) n_pass++;
        else $display("FAIL %s.data: got %h expected %h", e.nm, a_dat, e.data);
      end
    end
  end

  task automatic cyc(input string nm, input logic [2:0] chk, input logic [12:0] ec,
                     input logic [23:0] ed, input logic [3:0] eccr);
    exp_t e;
    e.nm = nm; e.chk = chk; e.ctrl = ec; e.data = ed; e.ccr = eccr;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; flush = 0; ex_valid = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_stack_push = 0; ex_stack_pop = 0;
    ex_wb_sel = '0; ex_mem_src = '0; ex_rd = '0;
    ex_alu_result = '0; ex_store_data = '0; ex_sp_value = '0;
    ex_alu_flags = '0; ex_flags_we = '0; ex_setc = 0; ex_clrc = 0;
    ex_restore_flags = 0; restore_value = '0; int_save = 0; int_restore = 0;
  endtask

  initial begin
    logic [3:0] exp_ret;
    // Reset with every input high
    rst_n = 0; stall = 1; flush = 1; ex_valid = 1;
    ex_reg_write = 1; ex_mem_read = 1; ex_mem_write = 1; ex_stack_push = 1; ex_stack_pop = 1;
    ex_wb_sel = '1; ex_mem_src = '1; ex_rd = '1;
    ex_alu_result = '1; ex_store_data = '1; ex_sp_value = '1;
    ex_alu_flags = '1; ex_flags_we = '1; ex_setc = 1; ex_clrc = 1;
    ex_restore_flags = 1; restore_value = '1; int_save = 1; int_restore = 1;
    cyc("reset", C_ALL, '0, '0, 4'b0000);
    cyc("reset2", C_ALL, '0, '0, 4'b0000);

    idle(); rst_n = 1;
    ex_valid = 1; ex_reg_write = 1; ex_alu_result = 8'h5A; ex_rd = 2'd2; ex_wb_sel = 3'd1;
    ex_store_data = 8'h33; ex_sp_value = 8'hF0;
    cyc("capture", C_ALL, ctl(1,1,0,0,0,0,3'd1,2'd0,2'd2), 24'h5A33F0, 4'b0000);

    idle(); ex_valid = 1; ex_alu_flags = 4'b1111; ex_flags_we = 4'b0011;
    cyc("masked_flags", C_CCR | C_CTL, ctl(1,0,0,0,0,0,3'd0,2'd0,2'd0), '0, 4'b0011);

    idle(); ex_valid = 1; ex_mem_read = 1; ex_rd = 2'd1; ex_alu_result = 8'h80;
    ex_store_data = 8'h44; ex_sp_value = 8'h10; ex_wb_sel = 3'd2; ex_mem_src = 2'd1;
    cyc("load", C_ALL, ctl(1,0,1,0,0,0,3'd2,2'd1,2'd1), 24'h804410, 4'b0011);

    for (int i = 0; i < 3; i++) begin
      idle(); stall = 1; ex_valid = 1; ex_mem_write = 1; ex_setc = 1;
      ex_alu_flags = 4'b1111; ex_flags_we = 4'b1111; int_save = 1;
      ex_alu_result = 8'(i + 1); ex_rd = 2'(i);
      cyc("stall_hold", C_ALL, ctl(1,0,1,0,0,0,3'd2,2'd1,2'd1), 24'h804410, 4'b0011);
    end

    idle(); stall = 1; flush = 1; ex_valid = 1; ex_reg_write = 1; ex_setc = 1; ex_alu_result = 8'hAA;
    cyc("flush_stall", C_ALL, '0, '0, 4'b0011);

    idle(); ex_valid = 1; ex_restore_flags = 1; restore_value = 4'b0000; ex_setc = 1;
    cyc("restore0", C_CCR | C_CTL, ctl(1,0,0,0,0,0,3'd0,2'd0,2'd0), '0, 4'b0000);

    idle(); ex_valid = 1; ex_setc = 1; ex_clrc = 1; ex_flags_we = 4'b0001; ex_alu_flags = 4'b0001;
    cyc("setc_clrc", C_CCR, '0, '0, 4'b0001);

    idle(); ex_valid = 1; ex_restore_flags = 1; restore_value = 4'b1010;
    ex_clrc = 1; ex_flags_we = 4'b1111;
    cyc("restore_1010", C_CCR, '0, '0, 4'b1010);

    idle(); ex_mem_write = 1; ex_setc = 1; ex_rd = 2'd3;
    cyc("bubble", C_CCR | C_CTL, '0, '0, 4'b1010);

    idle(); flush = 1; ex_valid = 1; ex_setc = 1; ex_reg_write = 1; ex_alu_result = 8'h99;
    cyc("flush_only", C_ALL, '0, '0, 4'b1010);

    idle(); ex_valid = 1; ex_restore_flags = 1; restore_value = 4'b0110;
    cyc("restore_0110", C_CCR, '0, '0, 4'b0110);

    idle(); int_save = 1;
    cyc("int_save", C_CCR, '0, '0, 4'b0110);

    idle(); ex_valid = 1; ex_setc = 1;
    cyc("setc_after_save", C_CCR, '0, '0, 4'b0110);

    idle(); ex_valid = 1; ex_clrc = 1;
    cyc("clrc", C_CCR, '0, '0, 4'b0010);

    idle(); stall = 1; int_restore = 1;
    cyc("stalled_restore", C_CCR | C_CTL, ctl(1,0,0,0,0,0,3'd0,2'd0,2'd0), '0, 4'b0010);

`ifdef FLAG_SHADOW_EN
    exp_ret = 4'b0110;
`else
    exp_ret = 4'b0010;
`endif
    idle(); int_restore = 1;
    cyc("int_restore", C_CCR | C_CTL, '0, '0, exp_ret);

    idle(); ex_valid = 1; ex_reg_write = 1; ex_alu_result = 8'h77;
    ex_flags_we = 4'b1111; ex_alu_flags = 4'b1000;
    cyc("commit_pre_rst", C_ALL, ctl(1,1,0,0,0,0,3'd0,2'd0,2'd0), 24'h770000, 4'b1000);

    idle(); stall = 1; rst_n = 0; ex_valid = 1;
    cyc("reset_mid_stall", C_ALL, '0, '0, 4'b0000);

    idle(); rst_n = 1;
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
